// File: rtl/reg_file_pkg.sv
// Shared sizes and types for the register file.
// Register 0 is the hardwired zero register.
package reg_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port of the register file.
// Index 0 always reads as zero, whatever the array holds.
module reg_file_read_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [DATA_WIDTH-1:0] regs_i [2**ADDR_WIDTH],
    input  logic [ADDR_WIDTH-1:0] sel_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    import reg_file_pkg::*;

    always_comb begin
        data_o = '0;
        if (sel_i != ADDR_WIDTH'(ZERO_REG)) begin
            data_o = regs_i[sel_i];
        end
    end

endmodule

// File: rtl/reg_file.sv
// 2-read / 1-write register file with a hardwired zero register.
// Writes land on the rising edge; reads never bypass pending writes.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wEn,
    input  logic [ADDR_WIDTH-1:0] write_sel,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_sel1,
    input  logic [ADDR_WIDTH-1:0] read_sel2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    import reg_file_pkg::*;

    localparam int NREGS = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] reg_file [NREGS];
    logic [NREGS-1:0]      wr_dec;

    // One-hot write strobe; index 0 is never selected.
    always_comb begin
        wr_dec = '0;
        if (wEn && (write_sel != ADDR_WIDTH'(ZERO_REG))) begin
            wr_dec[write_sel] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                reg_file[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_dec[i]) begin
                    reg_file[i] <= write_data;
                end
            end
        end
    end

    reg_file_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rd1 (
        .regs_i(reg_file),
        .sel_i (read_sel1),
        .data_o(read_data1)
    );

    reg_file_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rd2 (
        .regs_i(reg_file),
        .sel_i (read_sel2),
        .data_o(read_data2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected reads,
// a monitor pops and compares them against the DUT.
module tb_reg_file;

    import reg_file_pkg::*;

    logic      clock;
    logic      reset;
    logic      wEn;
    reg_idx_t  write_sel;
    reg_word_t write_data;
    reg_idx_t  read_sel1;
    reg_idx_t  read_sel2;
    reg_word_t read_data1;
    reg_word_t read_data2;

    reg_file dut (
        .clock     (clock),
        .reset     (reset),
        .wEn       (wEn),
        .write_sel (write_sel),
        .write_data(write_data),
        .read_sel1 (read_sel1),
        .read_sel2 (read_sel2),
        .read_data1(read_data1),
        .read_data2(read_data2)
    );

    typedef struct {
        string     name;
        reg_word_t e1;
        reg_word_t e2;
        bit        arr;
    } exp_t;

    exp_t      sb[$];
    reg_word_t mdl [32];
    int        checks = 0;
    int        errors = 0;
    event      chk_ev;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic reg_word_t model_rd(input int s);
        return (s == 0) ? 32'h0 : mdl[s];
    endfunction

    // Monitor: each check event pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: no expectation queued");
            end else begin
                e = sb.pop_front();
                if (read_data1 !== e.e1) begin
                    errors++;
                    $display("FAIL %s rd1: got %h want %h",
                             e.name, read_data1, e.e1);
                end
                checks++;
                if (read_data2 !== e.e2) begin
                    errors++;
                    $display("FAIL %s rd2: got %h want %h",
                             e.name, read_data2, e.e2);
                end
                if (e.arr) begin
                    for (int i = 0; i < 32; i++) begin
                        checks++;
                        if (dut.reg_file[i] !== mdl[i]) begin
                            errors++;
                            $display("FAIL %s arr[%0d]: got %h want %h",
                                     e.name, i, dut.reg_file[i], mdl[i]);
                        end
                    end
                end
            end
        end
    end

    task automatic expect_now(input string nm, input bit arr);
        exp_t e;
        e.name = nm;
        e.e1   = model_rd(int'(read_sel1));
        e.e2   = model_rd(int'(read_sel2));
        e.arr  = arr;
        sb.push_back(e);
        ->chk_ev;
        #0;
    endtask

    // Drive one write cycle, check before and after the edge.
    task automatic cycle(input string nm, input bit we,
                         input int ws, input reg_word_t wd,
                         input int s1, input int s2);
        wEn        = we;
        write_sel  = reg_idx_t'(ws);
        write_data = wd;
        read_sel1  = reg_idx_t'(s1);
        read_sel2  = reg_idx_t'(s2);
        #1;
        expect_now({nm, "_pre"}, 1'b0);
        @(posedge clock);
        if (reset && we && ws != 0) mdl[ws] = wd;
        #1;
        expect_now({nm, "_post"}, 1'b1);
        wEn = 1'b0;
        #2;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        reset      = 1'b0;
        wEn        = 1'b0;
        write_sel  = '0;
        write_data = '0;
        read_sel1  = '0;
        read_sel2  = '0;

        #20;
        for (int i = 0; i < 32; i++) begin
            read_sel1 = reg_idx_t'(i);
            read_sel2 = reg_idx_t'(31 - i);
            #1;
            expect_now("reset_hold", i == 0);
        end

        @(negedge clock);
        reset = 1'b1;
        #1;

        cycle("wr_zero", 1'b1, 0, 32'hffffffff, 0, 0);
        cycle("wr_norm", 1'b1, 1, 32'hffffffff, 0, 1);
        cycle("wr_dis", 1'b0, 2, 32'h12345678, 2, 2);
        cycle("setup5", 1'b1, 5, 32'hA5A5A5A5, 0, 0);
        cycle("rdw5", 1'b1, 5, 32'h0F0F0F0F, 5, 5);

        for (int n = 0; n < 300; n++) begin
            cycle("rand", 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 31)), $urandom,
                  int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)));
        end

        cycle("wr31", 1'b1, 31, 32'hDEADBEEF, 31, 31);
        @(negedge clock);
        read_sel1 = 5'd31;
        read_sel2 = 5'd1;
        #1;
        expect_now("pre_async", 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        #1;
        expect_now("async_rst", 1'b1);

        cycle("wr_in_rst", 1'b1, 7, 32'h77777777, 7, 7);

        @(negedge clock);
        reset = 1'b1;
        #1;
        cycle("wr3", 1'b1, 3, 32'h11111111, 3, 0);
        wEn        = 1'b1;
        write_sel  = 5'd3;
        write_data = 32'h22222222;
        read_sel1  = 5'd3;
        read_sel2  = 5'd3;
        @(posedge clock);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        #1;
        expect_now("edge_rst", 1'b1);

        #20;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d pending, want 0",
                     sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
